// File: rtl/occupancy_counter.sv
// occupancy_counter: debounced enter/leave head-count with seven-segment readout,
// warning LED and a blinking full-capacity LED.

module occupancy_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned DW = CYCLES > 1 ? $clog2(CYCLES) : 1;

    logic          s1, s2, deb, prev;
    logic [DW-1:0] c;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            deb  <= 1'b0;
            prev <= 1'b0;
            c    <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            prev <= deb;
            if (s2 == deb)
                c <= '0;
            else if (c == DW'(CYCLES - 1)) begin
                deb <= s2;
                c   <= '0;
            end else
                c <= c + 1'b1;
        end
    end

    // only the press edge counts; releases are silent
    assign pulse = deb & ~prev;
endmodule

module occupancy_counter #(
    parameter int NUM_DIGITS      = 2,
    parameter int MAX_COUNT       = 20,
    parameter int WARN_LEVEL      = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 12500000,
    localparam int CW = $clog2(MAX_COUNT + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    inc_btn,
    input  logic                    dec_btn,
    output logic [CW-1:0]           count,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    led_warn,
    output logic                    led_full
);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [79:0] SEG = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                   8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    if (MAX_COUNT >= 10**NUM_DIGITS) begin : g_err_digits
        $error("MAX_COUNT does not fit in NUM_DIGITS decimal digits");
    end
    if (WARN_LEVEL > MAX_COUNT) begin : g_err_warn
        $error("WARN_LEVEL exceeds MAX_COUNT");
    end
    if (DEBOUNCE_CYCLES < 1 || BLINK_DIV < 1) begin : g_err_div
        $error("DEBOUNCE_CYCLES and BLINK_DIV must be at least 1");
    end

    logic                    inc_pulse, dec_pulse;
    logic                    en_q, blink;
    logic [BW-1:0]           pre;
    logic [8*NUM_DIGITS-1:0] seg_next;

    occupancy_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clock(clock), .reset(reset), .btn(inc_btn), .pulse(inc_pulse)
    );
    occupancy_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clock(clock), .reset(reset), .btn(dec_btn), .pulse(dec_pulse)
    );

    always_ff @(posedge clock) begin
        if (reset || !enable)
            count <= '0;
        else if (inc_pulse && !dec_pulse && count != CW'(MAX_COUNT))
            count <= count + 1'b1;
        else if (dec_pulse && !inc_pulse && count != '0)
            count <= count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre   <= '0;
            blink <= 1'b0;
        end else if (pre == BW'(BLINK_DIV - 1)) begin
            pre   <= '0;
            blink <= ~blink;
        end else
            pre <= pre + 1'b1;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam int unsigned P = 32'(10**i);
        logic [3:0] d;
        assign d = 4'((32'(count) / P) % 32'd10);
        assign seg_next[8*i +: 8] = SEG[8*d +: 8];
    end

    // enable is delayed so the display blanks one edge after count clears
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q     <= 1'b0;
            hex_out  <= '1;
            led_warn <= 1'b0;
            led_full <= 1'b0;
        end else begin
            en_q     <= enable;
            hex_out  <= en_q ? seg_next : '1;
            led_warn <= en_q && count >= CW'(WARN_LEVEL);
            led_full <= en_q && count == CW'(MAX_COUNT) && blink;
        end
    end
endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter: randomized and directed checks against a press-scheduling reference model.

module tb_occupancy_counter;
    localparam int ND    = 2;
    localparam int MAXC  = 20;
    localparam int WARN  = 10;
    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam logic [7:0] SEGS [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            inc_btn = 1'b0;
    logic            dec_btn = 1'b0;
    logic [4:0]      count;
    logic [8*ND-1:0] hex_out;
    logic            led_warn, led_full;

    occupancy_counter #(
        .NUM_DIGITS(ND), .MAX_COUNT(MAXC), .WARN_LEVEL(WARN),
        .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BLINK)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .count(count), .hex_out(hex_out), .led_warn(led_warn), .led_full(led_full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_rst = 0;
    int m_cnt = 0;
    int p_cnt = 0;
    bit p_en = 0;
    bit p_blink = 0;
    int inc_due[$];
    int dec_due[$];
    logic [8*ND-1:0] exp_hex;
    bit exp_warn, exp_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [8*ND-1:0] enc(input int c);
        logic [8*ND-1:0] r;
        int v = c;
        for (int i = 0; i < ND; i++) begin
            r[8*i +: 8] = SEGS[v % 10];
            v = v / 10;
        end
        return r;
    endfunction

    // a press held at least DEB edges, first sampled at the next edge, pulses DEB+2 edges later
    task automatic sched(input bit i, input bit d);
        if (i) inc_due.push_back(cyc + 3 + DEB);
        if (d) dec_due.push_back(cyc + 3 + DEB);
    endtask

    task automatic step();
        bit pi, pd;
        @(posedge clock);
        #1;
        cyc++;
        pi = inc_due.size() > 0 && inc_due[0] == cyc;
        pd = dec_due.size() > 0 && dec_due[0] == cyc;
        if (pi) void'(inc_due.pop_front());
        if (pd) void'(dec_due.pop_front());
        if (reset) begin
            inc_due.delete();
            dec_due.delete();
            m_cnt = 0;
            t_rst = cyc;
            exp_hex = '1;
            exp_warn = 0;
            exp_full = 0;
            p_en = 0;
            p_cnt = 0;
            p_blink = 0;
        end else begin
            exp_hex  = p_en ? enc(p_cnt) : '1;
            exp_warn = p_en && p_cnt >= WARN;
            exp_full = p_en && p_cnt == MAXC && p_blink;
            if (!enable) m_cnt = 0;
            else if (pi && !pd && m_cnt < MAXC) m_cnt++;
            else if (pd && !pi && m_cnt > 0) m_cnt--;
            p_en = enable;
            p_cnt = m_cnt;
            p_blink = ((cyc - t_rst) / BLINK) % 2 == 1;
        end
        check("count", 32'(count), 32'(m_cnt));
        check("hex", 32'(hex_out), 32'(exp_hex));
        check("warn", 32'(led_warn), 32'(exp_warn));
        check("full", 32'(led_full), 32'(exp_full));
    endtask

    task automatic press(input bit i, input bit d, input int len, input int gap);
        inc_btn = i;
        dec_btn = d;
        if (len >= DEB) sched(i, d);
        repeat (len) step();
        inc_btn = 0;
        dec_btn = 0;
        repeat (gap) step();
    endtask

    task automatic gen(inout int rem, inout bit hi, output logic raw, input bit is_inc, input int maxgap);
        if (rem == 0) begin
            if (hi) begin
                hi = 0;
                rem = $urandom_range(maxgap, DEB + 1);
            end else begin
                hi = 1;
                if ($urandom_range(3, 0) != 0) begin
                    rem = $urandom_range(3 * DEB, DEB);
                    sched(is_inc, !is_inc);
                end else
                    rem = $urandom_range(DEB - 1, 1);
            end
        end
        raw = hi;
    endtask

    initial begin
        int k, toggles;
        bit last_full;
        int ri_rem = DEB + 1, rd_rem = DEB + 1;
        bit ri_hi = 0, rd_hi = 0;
        repeat (2) step();
        reset = 0;
        repeat (3) step();
        check("blank_disabled", 32'(hex_out), 32'hFFFF);
        enable = 1;
        repeat (2) step();
        check("idle_hex", 32'(hex_out), 32'hC0C0);
        check("idle_count", 32'(count), 0);
        check("idle_leds", {led_warn, led_full}, 0);

        k = cyc + 1;
        inc_btn = 1;
        sched(1, 0);
        repeat (6) step();
        check("lat_before", 32'(count), 0);
        step();
        check("lat_at", 32'(count), 1);
        step();
        check("lat_hex", 32'(hex_out), 32'hC0F9);
        repeat (k + 9 - cyc) step();
        inc_btn = 0;
        repeat (DEB + 4) step();
        press(1, 0, 3, DEB + 4);
        check("short_glitch", 32'(count), 1);

        repeat (19) press(1, 0, DEB + 2, DEB + 2);
        check("full_count", 32'(count), 20);
        check("full_hex", 32'(hex_out), 32'hA4C0);
        check("full_warn", 32'(led_warn), 1);
        toggles = 0;
        last_full = led_full;
        repeat (40) begin
            step();
            if (led_full != last_full) toggles++;
            last_full = led_full;
        end
        check("full_blinks", 32'(toggles >= 4), 1);
        press(1, 0, DEB + 2, DEB + 2);
        check("saturate", 32'(count), 20);

        repeat (10) press(0, 1, DEB + 2, DEB + 2);
        check("dec_to_10", 32'(count), 10);
        press(0, 1, DEB + 2, DEB + 2);
        check("dec_9", 32'(count), 9);
        check("dec_9_warn", 32'(led_warn), 0);
        check("dec_9_hex", 32'(hex_out), 32'hC090);
        repeat (9) press(0, 1, DEB + 2, DEB + 2);
        press(0, 1, DEB + 2, DEB + 2);
        check("no_underflow", 32'(count), 0);

        repeat (5) press(1, 0, DEB + 2, DEB + 2);
        press(1, 1, DEB + 2, DEB + 2);
        check("both_pulses", 32'(count), 5);

        repeat (2) press(1, 0, DEB + 2, DEB + 2);
        check("at_7", 32'(count), 7);
        enable = 0;
        inc_btn = 1;
        sched(1, 0);
        step();
        check("en_clear", 32'(count), 0);
        step();
        check("en_blank", 32'(hex_out), 32'hFFFF);
        repeat (DEB + 2) step();
        enable = 1;
        repeat (2) step();
        check("en_back_hex", 32'(hex_out), 32'hC0C0);
        repeat (10) step();
        check("held_no_inc", 32'(count), 0);
        inc_btn = 0;
        repeat (DEB + 2) step();
        press(1, 0, DEB + 2, DEB + 2);
        check("repress", 32'(count), 1);

        repeat (14) press(1, 0, DEB + 2, DEB + 2);
        check("at_15", 32'(count), 15);
        inc_btn = 1;
        sched(1, 0);
        repeat (DEB) step();
        reset = 1;
        step();
        check("rst_count", 32'(count), 0);
        check("rst_hex", 32'(hex_out), 32'hFFFF);
        reset = 0;
        inc_btn = 0;
        repeat (20) step();
        check("rst_discard", 32'(count), 0);

        for (int n = 0; n < 3000; n++) begin
            gen(ri_rem, ri_hi, inc_btn, 1, 2 * DEB);
            gen(rd_rem, rd_hi, dec_btn, 0, 8 * DEB);
            if (enable ? $urandom_range(299, 0) == 0 : $urandom_range(7, 0) == 0)
                enable = ~enable;
            step();
            ri_rem--;
            rd_rem--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
